// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing. Horizontal/vertical counters, sync,
// blanking, and a registered colour/sync/blank output stage so the DAC pins
// are mutually aligned one pixel after the counters.
// Optional build macro VGA_TIMING_TESTPAT_EN adds a testpat_en input that
// swaps the colour source for an 8-bar test pattern.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
`ifdef VGA_TIMING_TESTPAT_EN
  input  logic       testpat_en,
`endif
  input  logic [7:0] pixel_r,
  input  logic [7:0] pixel_g,
  input  logic [7:0] pixel_b,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n
);

  // Totals must stay <= 1024 so every boundary fits the 10-bit counters.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]      h_cnt_q, h_cnt_d;
  logic [9:0]      v_cnt_q, v_cnt_d;
  logic [2:0][7:0] rgb_q, rgb_d;      // [2]=r, [1]=g, [0]=b
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            blank_n_q, blank_n_d;
  logic [2:0][7:0] src_rgb;

  // Raster status straight from the counters; downstream is combinational.
  always_comb begin
    active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    line_start  = pix_ce && (h_cnt_q == 10'd0);
    frame_start = pix_ce && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  // Counter advance: h wraps at H_LAST, v steps on each h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

`ifdef VGA_TIMING_TESTPAT_EN
  logic [9:0] bar_idx;
  // Colour source: eight 80-pixel bars, index bits map to r/g/b, or the
  // resolved generator bus.
  always_comb begin
    bar_idx = h_cnt_q / 10'd80;
    src_rgb = {pixel_r, pixel_g, pixel_b};
    if (testpat_en)
      src_rgb = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
  end
`else
  // Colour source: the resolved generator bus.
  always_comb begin
    src_rgb = {pixel_r, pixel_g, pixel_b};
  end
`endif

  // Output stage: sample colour/sync/blank for the current counters so all
  // pins carry the same pixel one pix_ce later. vsync is decided per pixel.
  always_comb begin
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    if (pix_ce) begin
      rgb_d     = active ? src_rgb : '0;
      blank_n_d = active;
      hs_d      = (h_cnt_q >= HS_FIRST && h_cnt_q <= HS_LAST) ? HS_POL : ~HS_POL;
      vs_d      = (v_cnt_q >= VS_FIRST && v_cnt_q <= VS_LAST) ? VS_POL : ~VS_POL;
    end
  end

  // State registers; reset parks sync at its inactive level and blanks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      rgb_q     <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_n_q <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign vga_r       = rgb_q[2];
  assign vga_g       = rgb_q[1];
  assign vga_b       = rgb_q[0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA timing generator. Default
// horizontal timing; vertical geometry shrunk (6/2/2/3 = 13 lines) so a full
// frame is 10400 pixels.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic [7:0] pixel_r, pixel_g, pixel_b;
  logic [9:0] pix_x, pix_y;
  logic       active, line_start, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n;
`ifdef VGA_TIMING_TESTPAT_EN
  logic       testpat_en = 1'b0;
`endif

  vga_timing_gen #(
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
`ifdef VGA_TIMING_TESTPAT_EN
    .testpat_en(testpat_en),
`endif
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .pix_x(pix_x), .pix_y(pix_y), .active(active),
    .line_start(line_start), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setpix(input logic [23:0] p);
    {pixel_r, pixel_g, pixel_b} = p;
  endtask

  function automatic int rgb();
    return int'({vga_r, vga_g, vga_b});
  endfunction

  // t = pix_ce edges since reset release; pix = colour bus during the run to t.
  typedef struct {
    int          t;
    logic [23:0] pix;
    int          x, y;
    bit          hs, vs, bl;
    logic [23:0] rgb;
    bit          ls, fs;
  } vec_t;

  vec_t vec[19];

  initial begin
    int cur_t;
    int hs_lo, bl_cnt, rgb_viol, hold_viol, ls_cnt, pulse_viol;
    logic [63:0] snap;
    bit ce_now;

    //          t      pix          x    y  hs vs bl rgb          ls fs
    vec[0]  = '{1,     24'h123456,  1,   0, 1, 1, 1, 24'h123456,  0, 0};
    vec[1]  = '{639,   24'habcdef,  639, 0, 1, 1, 1, 24'habcdef,  0, 0};
    vec[2]  = '{640,   24'h0f1e2d,  640, 0, 1, 1, 1, 24'h0f1e2d,  0, 0};
    vec[3]  = '{641,   24'h123456,  641, 0, 1, 1, 0, 24'h000000,  0, 0};
    vec[4]  = '{656,   24'h123456,  656, 0, 1, 1, 0, 24'h000000,  0, 0};
    vec[5]  = '{657,   24'h123456,  657, 0, 0, 1, 0, 24'h000000,  0, 0};
    vec[6]  = '{752,   24'h123456,  752, 0, 0, 1, 0, 24'h000000,  0, 0};
    vec[7]  = '{753,   24'h123456,  753, 0, 1, 1, 0, 24'h000000,  0, 0};
    vec[8]  = '{800,   24'h123456,  0,   1, 1, 1, 0, 24'h000000,  1, 0};
    vec[9]  = '{801,   24'hff0080,  1,   1, 1, 1, 1, 24'hff0080,  0, 0};
    vec[10] = '{4800,  24'h123456,  0,   6, 1, 1, 0, 24'h000000,  1, 0};
    vec[11] = '{4801,  24'h123456,  1,   6, 1, 1, 0, 24'h000000,  0, 0};
    vec[12] = '{6400,  24'h123456,  0,   8, 1, 1, 0, 24'h000000,  1, 0};
    vec[13] = '{6401,  24'h123456,  1,   8, 1, 0, 0, 24'h000000,  0, 0};
    vec[14] = '{8000,  24'h123456,  0,  10, 1, 0, 0, 24'h000000,  1, 0};
    vec[15] = '{8001,  24'h123456,  1,  10, 1, 1, 0, 24'h000000,  0, 0};
    vec[16] = '{10399, 24'h123456,  799,12, 1, 1, 0, 24'h000000,  0, 0};
    vec[17] = '{10400, 24'h123456,  0,   0, 1, 1, 0, 24'h000000,  1, 1};
    vec[18] = '{10401, 24'h123456,  1,   0, 1, 1, 1, 24'h123456,  0, 0};

    // Reset held with pix_ce high
    rst_n = 1'b0;
    pix_ce = 1'b1;
    setpix(24'h123456);
    step(3);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_blank_n", vga_blank_n, 0);
    chk("rst_rgb", rgb(), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_frame_start", frame_start, 1);

    // Table walk through one full frame at pix_ce = 1
    cur_t = 0;
    for (int i = 0; i < 19; i++) begin
      setpix(vec[i].pix);
      step(vec[i].t - cur_t);
      cur_t = vec[i].t;
      chk($sformatf("v%0d_x", i), pix_x, vec[i].x);
      chk($sformatf("v%0d_y", i), pix_y, vec[i].y);
      chk($sformatf("v%0d_hs", i), vga_hs, vec[i].hs);
      chk($sformatf("v%0d_vs", i), vga_vs, vec[i].vs);
      chk($sformatf("v%0d_blank_n", i), vga_blank_n, vec[i].bl);
      chk($sformatf("v%0d_rgb", i), rgb(), int'(vec[i].rgb));
      chk($sformatf("v%0d_line_start", i), line_start, vec[i].ls);
      chk($sformatf("v%0d_frame_start", i), frame_start, vec[i].fs);
    end

    // One line from (1,0): hsync width, active width, colour gating
    hs_lo = 0; bl_cnt = 0; rgb_viol = 0;
    for (int i = 0; i < 800; i++) begin
      step(1);
      if (!vga_hs) hs_lo++;
      if (vga_blank_n) begin
        bl_cnt++;
        if (rgb() != 24'h123456) rgb_viol++;
      end else if (rgb() != 0) rgb_viol++;
    end
    chk("line_hs_low_cnt", hs_lo, 96);
    chk("line_blank_n_cnt", bl_cnt, 640);
    chk("line_rgb_viol", rgb_viol, 0);
    chk("line_end_x", pix_x, 1);
    chk("line_end_y", pix_y, 1);

    // pix_ce 1-of-2: outputs hold on idle cycles, one line = 1600 clk
    hold_viol = 0; ls_cnt = 0; pulse_viol = 0;
    for (int i = 0; i < 1600; i++) begin
      ce_now = (i % 2 == 0);
      pix_ce = ce_now;
      setpix(24'(i * 7));
      #2;
      if (line_start) begin
        if (ce_now) ls_cnt++; else pulse_viol++;
      end
      if (frame_start) pulse_viol++;
      snap = {pix_x, pix_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, 17'd0};
      @(posedge clk); #1;
      if (!ce_now &&
          snap != {pix_x, pix_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, 17'd0})
        hold_viol++;
    end
    chk("ce_hold_viol", hold_viol, 0);
    chk("ce_pulse_viol", pulse_viol, 0);
    chk("ce_line_start_cnt", ls_cnt, 1);
    chk("ce_end_x", pix_x, 1);
    chk("ce_end_y", pix_y, 2);

    // Mid-frame reset at (300,4)
    pix_ce = 1'b1;
    setpix(24'h55aa33);
    step(1899);
    chk("mid_x", pix_x, 300);
    chk("mid_y", pix_y, 4);
    chk("mid_blank_n", vga_blank_n, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_x", pix_x, 0);
    chk("mid_rst_y", pix_y, 0);
    chk("mid_rst_blank_n", vga_blank_n, 0);
    chk("mid_rst_rgb", rgb(), 0);
    chk("mid_rst_hs", vga_hs, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("restart_frame_start", frame_start, 1);
    chk("restart_line_start", line_start, 1);
    step(1);
    chk("restart_x", pix_x, 1);
    chk("restart_y", pix_y, 0);
    chk("restart_blank_n", vga_blank_n, 1);
    chk("restart_rgb", rgb(), 24'h55aa33);
    chk("restart_frame_start_off", frame_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
